link_frame_sequencer: RTL and testbench

Parametrised transmit/receive frame sequencer for the coded QPSK link chain. It takes a whole coded, interleaved frame and serialises it into SYM_W-bit symbols for the modulator, with an optional bit-error mask applied. It then reassembles the symbols returned by the demodulator after a fixed channel latency into a frame for the deinterleaver. It replaces the hard-coded per-symbol counter/case sequencing with a generic width, symbol size and latency, plus explicit start/done handshakes.

---
 rtl/link_pkg.sv | 19 +
 rtl/valid_delay_line.sv | 26 ++
 rtl/link_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_link_frame_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and defaults for the link frame sequencer and related link blocks.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_FRAME_W = 28;
    localparam int DEF_SYM_W   = 2;
    localparam int DEF_LAT     = 3;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage registered pipeline for a single valid bit; cleared by async reset.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign q = r_pipe[DEPTH-1];

endmodule

// File: rtl/link_frame_sequencer.sv
// Serialises a frame into SYM_W-bit symbols (LSB first) and reassembles the
// symbols returned LAT cycles later into a received frame.
module link_frame_sequencer
    import link_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int SYM_W   = DEF_SYM_W,
    parameter int LAT     = DEF_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [FRAME_W-1:0] err_mask_i,
    output logic               busy_o,
    output logic [SYM_W-1:0]   sym_o,
    output logic               sym_valid_o,
    input  logic [SYM_W-1:0]   sym_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               frame_valid_o,
    output logic               done_o
);

    localparam int NUM_SYM = ceil_div(FRAME_W, SYM_W);
    localparam int BUF_W   = NUM_SYM * SYM_W;
    localparam int CNT_W   = $clog2(NUM_SYM + 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(NUM_SYM - 1);
    localparam logic [CNT_W-1:0] ALL_RX  = CNT_W'(NUM_SYM);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_finish;
    logic               w_sym_valid_nxt;
    logic               w_rx_valid;

    logic [BUF_W-1:0]   r_tx_buf;
    logic [BUF_W-1:0]   r_rx_buf;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [SYM_W-1:0]   r_sym;
    logic               r_sym_valid;
    logic [FRAME_W-1:0] r_frame;
    logic               r_frame_valid;
    logic               r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (r_tx_cnt == LAST_TX) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_rx_cnt == ALL_RX) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_sym_valid_nxt = (r_state == SEND);

    // Fed with the value being loaded into sym_valid_o, so stage 0 mirrors
    // sym_valid_o and a symbol launched at edge n is captured at edge n+LAT.
    valid_delay_line #(
        .DEPTH (LAT)
    ) u_valid_delay (
        .clk (clk),
        .rst (rst),
        .d   (w_sym_valid_nxt),
        .q   (w_rx_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_buf      <= '0;
            r_rx_buf      <= '0;
            r_tx_cnt      <= '0;
            r_rx_cnt      <= '0;
            r_sym         <= '0;
            r_sym_valid   <= 1'b0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_sym_valid <= w_sym_valid_nxt;
            r_done      <= w_finish;
            if (r_state == SEND) begin
                r_sym    <= r_tx_buf[SYM_W-1:0];
                r_tx_buf <= r_tx_buf >> SYM_W;
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            // Symbols enter at the top; after NUM_SYM shifts symbol 0 sits at bit 0.
            if (w_rx_valid) begin
                r_rx_buf <= (r_rx_buf >> SYM_W) | (BUF_W'(sym_i) << (BUF_W - SYM_W));
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_accept) begin
                r_tx_buf      <= BUF_W'(frame_i ^ err_mask_i);
                r_tx_cnt      <= '0;
                r_rx_cnt      <= '0;
                r_frame_valid <= 1'b0;
            end
            if (w_finish) begin
                r_frame       <= r_rx_buf[FRAME_W-1:0];
                r_frame_valid <= 1'b1;
            end
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign sym_o         = r_sym;
    assign sym_valid_o   = r_sym_valid;
    assign frame_o       = r_frame;
    assign frame_valid_o = r_frame_valid;
    assign done_o        = r_done;

endmodule

// File: tb/tb_link_frame_sequencer.sv
// Bench for link_frame_sequencer: a default instance with a loopback channel and
// a small FRAME_W=7/LAT=1 instance, checked through expected-value queues.
module tb_link_frame_sequencer;

    localparam int AF = 28;
    localparam int AS = 2;
    localparam int AL = 3;
    localparam int AN = 14;
    localparam int BF = 7;
    localparam int BS = 2;
    localparam int BL = 1;
    localparam int BN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_start, a_busy, a_sym_valid, a_frame_valid, a_done;
    logic [AF-1:0] a_frame_i, a_mask, a_frame_o;
    logic [AS-1:0] a_sym_o, a_sym_i, a_ch1, a_ch2;
    logic          b_start, b_busy, b_sym_valid, b_frame_valid, b_done;
    logic [BF-1:0] b_frame_i, b_mask, b_frame_o;
    logic [BS-1:0] b_sym_o, b_sym_i;

    link_frame_sequencer dut_a (
        .clk (clk), .rst (rst), .start_i (a_start), .frame_i (a_frame_i),
        .err_mask_i (a_mask), .busy_o (a_busy), .sym_o (a_sym_o),
        .sym_valid_o (a_sym_valid), .sym_i (a_sym_i), .frame_o (a_frame_o),
        .frame_valid_o (a_frame_valid), .done_o (a_done)
    );

    link_frame_sequencer #(.FRAME_W(BF), .SYM_W(BS), .LAT(BL)) dut_b (
        .clk (clk), .rst (rst), .start_i (b_start), .frame_i (b_frame_i),
        .err_mask_i (b_mask), .busy_o (b_busy), .sym_o (b_sym_o),
        .sym_valid_o (b_sym_valid), .sym_i (b_sym_i), .frame_o (b_frame_o),
        .frame_valid_o (b_frame_valid), .done_o (b_done)
    );

    // Channel: sym_o launched at edge n must be on sym_i before edge n+LAT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ch1 <= '0;
            a_ch2 <= '0;
        end else begin
            a_ch1 <= a_sym_o;
            a_ch2 <= a_ch1;
        end
    end
    assign a_sym_i = a_ch2;
    assign b_sym_i = b_sym_o;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int t0_a = 0, t0_b = 0;
    int n_checks = 0, n_fail = 0;
    int a_done_cnt = 0, b_done_cnt = 0;

    logic [AS-1:0] a_sym_q[$];
    logic [AF-1:0] a_frm_q[$];
    int            a_cyc_q[$];
    logic [BS-1:0] b_sym_q[$];
    logic [BF-1:0] b_frm_q[$];
    int            b_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation whenever a DUT presents a symbol or a done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_sym_valid) begin
                chk("a_sym_expected", a_sym_q.size() != 0, 1);
                if (a_sym_q.size() != 0) chk("a_sym", a_sym_o, a_sym_q.pop_front());
            end
            if (a_done) begin
                a_done_cnt++;
                chk("a_done_expected", a_frm_q.size() != 0, 1);
                if (a_frm_q.size() != 0) begin
                    chk("a_frame_o", a_frame_o, a_frm_q.pop_front());
                    chk("a_frame_valid", a_frame_valid, 1);
                    chk("a_done_cycle", edge_cnt - t0_a, a_cyc_q.pop_front());
                end
            end
            if (b_sym_valid) begin
                chk("b_sym_expected", b_sym_q.size() != 0, 1);
                if (b_sym_q.size() != 0) chk("b_sym", b_sym_o, b_sym_q.pop_front());
            end
            if (b_done) begin
                b_done_cnt++;
                chk("b_done_expected", b_frm_q.size() != 0, 1);
                if (b_frm_q.size() != 0) begin
                    chk("b_frame_o", b_frame_o, b_frm_q.pop_front());
                    chk("b_frame_valid", b_frame_valid, 1);
                    chk("b_done_cycle", edge_cnt - t0_b, b_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic start_a(input logic [AF-1:0] frm, input logic [AF-1:0] mask, input logic [AF-1:0] exp);
        logic [AN*AS-1:0] v;
        v = frm ^ mask;
        for (int k = 0; k < AN; k++) a_sym_q.push_back(v[k*AS +: AS]);
        a_frm_q.push_back(exp);
        a_cyc_q.push_back(AN + AL + 1);
        a_frame_i = frm;
        a_mask    = mask;
        a_start   = 1'b1;
        @(posedge clk);
        #1;
        t0_a    = edge_cnt;
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [BF-1:0] frm, input logic [BF-1:0] mask, input logic [BF-1:0] exp);
        logic [BN*BS-1:0] v;
        v = {1'b0, frm ^ mask};
        for (int k = 0; k < BN; k++) b_sym_q.push_back(v[k*BS +: BS]);
        b_frm_q.push_back(exp);
        b_cyc_q.push_back(BN + BL + 1);
        b_frame_i = frm;
        b_mask    = mask;
        b_start   = 1'b1;
        @(posedge clk);
        #1;
        t0_b    = edge_cnt;
        b_start = 1'b0;
    endtask

    task automatic wait_idle_a(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!a_busy && a_frm_q.size() == 0) break;
        end
        chk("a_wait_idle_in_time", i < bound, 1);
    endtask

    task automatic wait_idle_b(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!b_busy && b_frm_q.size() == 0) break;
        end
        chk("b_wait_idle_in_time", i < bound, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        a_start = 0; a_frame_i = '0; a_mask = '0;
        b_start = 0; b_frame_i = '0; b_mask = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_sym_valid", a_sym_valid, 0);
        chk("rst_a_sym_o", a_sym_o, 0);
        chk("rst_a_frame_valid", a_frame_valid, 0);
        chk("rst_a_frame_o", a_frame_o, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_frame_valid", b_frame_valid, 0);

        // Test 1: plain loopback.
        start_a(28'h1234567, 28'h0, 28'h1234567);
        chk("t1_busy", a_busy, 1);
        @(posedge clk); #1; chk("t1_sym0", a_sym_o, 2'b11);
        @(posedge clk); #1; chk("t1_sym1", a_sym_o, 2'b01);
        @(posedge clk); #1; chk("t1_sym2", a_sym_o, 2'b10);
        wait_idle_a(40);
        chk("t1_done_count", a_done_cnt, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_frame_valid_hold", a_frame_valid, 1);
        chk("t1_frame_o_hold", a_frame_o, 28'h1234567);

        // Test 2: error mask flips the top nibble.
        start_a(28'h1234567, 28'hF000000, 28'hE234567);
        chk("t2_frame_valid_cleared", a_frame_valid, 0);
        chk("t2_frame_o_kept", a_frame_o, 28'h1234567);
        wait_idle_a(40);

        // Test 3: small instance, last symbol zero-padded.
        start_b(7'h55, 7'h0, 7'h55);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_last_sym_padded", b_sym_o, 2'b01);
        wait_idle_b(20);
        chk("t3_b_done_count", b_done_cnt, 1);

        // Test 4: start while busy is ignored.
        dc = a_done_cnt;
        start_a(28'hABCDEF1, 28'h0, 28'hABCDEF1);
        repeat (5) @(posedge clk);
        #1;
        a_start = 1'b1; a_frame_i = 28'h5555555; a_mask = 28'h00FF000;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        wait_idle_a(40);
        repeat (30) @(posedge clk);
        #1;
        chk("t4_single_done", a_done_cnt - dc, 1);
        chk("t4_idle_after", a_busy, 0);

        // Test 5: reset mid-frame, then a clean frame.
        start_a(28'h0F0F0F0, 28'h0, 28'h0F0F0F0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_busy", a_busy, 0);
        chk("t5_sym_valid", a_sym_valid, 0);
        chk("t5_frame_valid", a_frame_valid, 0);
        chk("t5_sym_o", a_sym_o, 0);
        chk("t5_frame_o", a_frame_o, 0);
        a_sym_q.delete(); a_frm_q.delete(); a_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_a(28'h7654321, 28'h0, 28'h7654321);
        wait_idle_a(40);

        // Test 6: start in the done cycle is ignored, next cycle accepted.
        start_a(28'h1357924, 28'h0, 28'h1357924);
        repeat (AN + AL + 1) @(posedge clk);
        #1;
        chk("t6_done_cycle18", a_done, 1);
        a_start = 1'b1; a_frame_i = 28'hDEAD000; a_mask = 28'h0;
        @(posedge clk);
        #1;
        chk("t6_ignored_start", a_busy, 0);
        start_a(28'h2468ACE, 28'h0, 28'h2468ACE);
        wait_idle_a(40);

        repeat (5) @(posedge clk);
        #1;
        chk("end_a_sym_q_empty", a_sym_q.size(), 0);
        chk("end_a_frm_q_empty", a_frm_q.size(), 0);
        chk("end_b_sym_q_empty", b_sym_q.size(), 0);
        chk("end_b_frm_q_empty", b_frm_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
